// File: rtl/channel_rr_merge.sv
// Round-robin merge of NumIn valid/ack channels into one source-tagged output behind a Depth-entry FIFO.
// Optional per-input accepted-word counters are enabled by defining CHANNEL_MERGE_COUNT_EN.
module channel_rr_merge #(
    parameter int N     = 8,
    parameter int NumIn = 4,
    parameter int Depth = 2,
    parameter int IdxW  = $clog2(NumIn)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NumIn*N-1:0]    in_d,
    input  logic [NumIn-1:0]      in_v,
    output logic [NumIn-1:0]      in_a,
    output logic [IdxW+N-1:0]     out_d,
    output logic                  out_v,
    input  logic                  out_a
`ifdef CHANNEL_MERGE_COUNT_EN
    ,
    output logic [NumIn*16-1:0]   xfer_count
`endif
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    typedef logic [IdxW+N-1:0] entry_t;

    entry_t          mem [Depth];
    logic [PtrW-1:0] head;
    logic [PtrW-1:0] tail;
    logic [CntW-1:0] count;
    logic [IdxW-1:0] rr_ptr;

    logic            grant_v;
    logic [IdxW-1:0] grant;
    logic            push;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Search starts one past the last winner so every requester is served within NumIn grants.
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        int cand;
        grant_v = 1'b0;
        grant   = '0;
        cand    = 0;
        if (count < CntW'(Depth)) begin
            for (int k = 1; k <= NumIn; k++) begin
                cand = (int'(rr_ptr) + k) % NumIn;
                if (!grant_v && in_v[cand]) begin
                    grant_v = 1'b1;
                    grant   = IdxW'(cand);
                end
            end
        end
    end

    assign in_a = grant_v ? (NumIn'(1) << grant) : '0;
    assign push = grant_v;
    assign pop  = out_v && out_a;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= IdxW'(NumIn - 1);
        end else begin
            if (push) begin
                tail   <= ptr_inc(tail);
                rr_ptr <= grant;
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; out_d is masked by out_v so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {grant, in_d[int'(grant)*N +: N]};
        end
    end

    assign out_v = (count != '0);
    assign out_d = out_v ? mem[head] : '0;

`ifdef CHANNEL_MERGE_COUNT_EN
    logic [15:0] cnt [NumIn];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumIn; i++) begin
                cnt[i] <= '0;
            end
        end else if (push) begin
            cnt[grant] <= cnt[grant] + 16'd1;
        end
    end

    always_comb begin
        xfer_count = '0;
        for (int i = 0; i < NumIn; i++) begin
            xfer_count[i*16 +: 16] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_channel_rr_merge.sv
// Directed and randomized-delay bench for channel_rr_merge (NumIn=4, N=8, Depth=2).
// Define CHANNEL_MERGE_COUNT_EN to also exercise the accepted-word counters.
module tb_channel_rr_merge;

    localparam int N     = 8;
    localparam int NumIn = 4;
    localparam int Depth = 2;
    localparam int IdxW  = 2;
    localparam int Limit = 20;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NumIn*N-1:0]   in_d;
    logic [NumIn-1:0]     in_v;
    logic [NumIn-1:0]     in_a;
    logic [IdxW+N-1:0]    out_d;
    logic                 out_v;
    logic                 out_a;
`ifdef CHANNEL_MERGE_COUNT_EN
    logic [NumIn*16-1:0]  xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    channel_rr_merge #(.N(N), .NumIn(NumIn), .Depth(Depth)) dut (
        .clk   (clk),
        .reset (reset),
        .in_d  (in_d),
        .in_v  (in_v),
        .in_a  (in_a),
        .out_d (out_d),
        .out_v (out_v),
        .out_a (out_a)
`ifdef CHANNEL_MERGE_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_d(input int i, input logic [N-1:0] v);
        in_d[i*N +: N] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_v  = '0;
        out_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_v  = '0;
        in_d  = '0;
        out_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_v !== 1'b0 || out_d !== '0 || in_a !== '0) begin
                errors++;
                $display("FAIL reset_state cycle %0d: out_v=%b out_d=%h in_a=%b, expected 0/000/0000",
                         c, out_v, out_d, in_a);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_all_rr();
        logic [IdxW+N-1:0] exp_d;
        logic [NumIn-1:0]  exp_a;
        do_reset();
        for (int i = 0; i < NumIn; i++) set_d(i, 8'hA0 + 8'(i));
        in_v  = 4'hF;
        out_a = 1'b1;
        #1;
        checks++;
        if (in_a !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first_grant: in_a=%b expected 0001", in_a);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            exp_d = {2'(k % 4), 8'hA0 + 8'(k % 4)};
            exp_a = 4'(1 << ((k + 1) % 4));
            checks++;
            if (out_v !== 1'b1 || out_d !== exp_d || in_a !== exp_a) begin
                errors++;
                $display("FAIL rr_sequence word %0d: out_v=%b out_d=%h in_a=%b, expected 1/%h/%b",
                         k, out_v, out_d, in_a, exp_d, exp_a);
            end
        end
        in_v = '0;
    endtask

    task automatic test_backpressure();
        logic [IdxW+N-1:0] exp_d;
        exp_d = {2'd2, 8'h5C};
        do_reset();
        set_d(2, 8'h5C);
        in_v  = 4'b0100;
        out_a = 1'b0;
        #1;
        checks++;
        if (in_a !== 4'b0100) begin
            errors++;
            $display("FAIL bp_first_ack: in_a=%b expected 0100", in_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (in_a !== 4'b0100 || out_v !== 1'b1 || out_d !== exp_d) begin
            errors++;
            $display("FAIL bp_second_ack: in_a=%b out_v=%b out_d=%h expected 0100/1/%h",
                     in_a, out_v, out_d, exp_d);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (in_a !== 4'b0000 || out_v !== 1'b1 || out_d !== exp_d) begin
                errors++;
                $display("FAIL bp_full_hold cycle %0d: in_a=%b out_v=%b out_d=%h expected 0000/1/%h",
                         c, in_a, out_v, out_d, exp_d);
            end
        end
        out_a = 1'b1;
        #1;
        checks++;
        if (in_a !== 4'b0000) begin
            errors++;
            $display("FAIL bp_no_passthrough: in_a=%b expected 0000", in_a);
        end
        @(negedge clk);
        out_a = 1'b0;
        #1;
        checks++;
        if (in_a !== 4'b0100 || out_v !== 1'b1 || out_d !== exp_d) begin
            errors++;
            $display("FAIL bp_after_pop: in_a=%b out_v=%b out_d=%h expected 0100/1/%h",
                     in_a, out_v, out_d, exp_d);
        end
        in_v = '0;
    endtask

    task automatic test_alternate();
        int g    [4] = '{3, 1, 3, 1};
        int prev [4] = '{1, 3, 1, 3};
        logic [IdxW+N-1:0] exp_d;
        do_reset();
        set_d(1, 8'h11);
        set_d(3, 8'h33);
        out_a = 1'b1;
        in_v  = 4'b0010;
        #1;
        checks++;
        if (in_a !== 4'b0010) begin
            errors++;
            $display("FAIL alt_setup: in_a=%b expected 0010", in_a);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) in_v = 4'b1010;
            #1;
            exp_d = {2'(prev[k]), (prev[k] == 1) ? 8'h11 : 8'h33};
            checks++;
            if (in_a !== 4'(1 << g[k]) || out_d !== exp_d) begin
                errors++;
                $display("FAIL alt_grant step %0d: in_a=%b out_d=%h expected %b/%h",
                         k, in_a, out_d, 4'(1 << g[k]), exp_d);
            end
        end
        in_v = '0;
    endtask

    task automatic test_reset_full();
        do_reset();
        set_d(0, 8'h42);
        in_v  = 4'b0001;
        out_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (out_v !== 1'b1 || in_a !== 4'b0000) begin
            errors++;
            $display("FAIL rf_full: out_v=%b in_a=%b expected 1/0000", out_v, in_a);
        end
        reset = 1'b1;
        in_v  = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_v !== 1'b0 || out_d !== '0 || in_a !== '0) begin
            errors++;
            $display("FAIL rf_after_reset: out_v=%b out_d=%h in_a=%b expected 0/000/0000",
                     out_v, out_d, in_a);
        end
        set_d(1, 8'h77);
        in_v = 4'b0010;
        #1;
        checks++;
        if (in_a !== 4'b0010) begin
            errors++;
            $display("FAIL rf_regrant: in_a=%b expected 0010", in_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_v !== 1'b1 || out_d !== {2'd1, 8'h77}) begin
            errors++;
            $display("FAIL rf_first_word: out_v=%b out_d=%h expected 1/177", out_v, out_d);
        end
        in_v = '0;
    endtask

    task automatic test_random();
        logic [N-1:0]      exp_q [NumIn][$];
        int                sent [NumIn];
        int                gap  [NumIn];
        int                sgap;
        int                received;
        int                cycle;
        logic [NumIn-1:0]  acc;
        logic              popped;
        logic              hold_prev;
        logic [IdxW+N-1:0] held;
        logic [IdxW-1:0]   tag;
        logic [N-1:0]      front;
        bit                done;
        do_reset();
        for (int i = 0; i < NumIn; i++) begin
            sent[i] = 0;
            gap[i]  = int'($urandom_range(0, 5));
        end
        sgap      = int'($urandom_range(0, 5));
        received  = 0;
        acc       = '0;
        popped    = 1'b0;
        hold_prev = 1'b0;
        held      = '0;
        done      = 1'b0;
        for (cycle = 0; cycle < 2000; cycle++) begin
            @(negedge clk);
            if (hold_prev) begin
                checks++;
                if (out_v !== 1'b1 || out_d !== held) begin
                    errors++;
                    $display("FAIL rnd_stall_stable cycle %0d: out_v=%b out_d=%h expected 1/%h",
                             cycle, out_v, out_d, held);
                end
            end
            for (int i = 0; i < NumIn; i++) begin
                if (acc[i]) begin
                    in_v[i] = 1'b0;
                    sent[i]++;
                    gap[i] = int'($urandom_range(0, 5));
                end
            end
            if (popped) begin
                out_a = 1'b0;
                sgap  = int'($urandom_range(0, 5));
            end
            done = (in_v == '0);
            for (int i = 0; i < NumIn; i++) begin
                if (sent[i] != Limit || exp_q[i].size() != 0) done = 1'b0;
            end
            if (done) break;
            for (int i = 0; i < NumIn; i++) begin
                if (!in_v[i]) begin
                    if (gap[i] > 0) gap[i]--;
                    else if (sent[i] < Limit) begin
                        set_d(i, 8'(i * 64 + sent[i]));
                        in_v[i] = 1'b1;
                    end
                end
            end
            if (!out_a) begin
                if (sgap > 0) sgap--;
                else out_a = 1'b1;
            end
            #1;
            checks++;
            if (!$onehot0(in_a) || (in_a & ~in_v) != '0) begin
                errors++;
                $display("FAIL rnd_ack_shape cycle %0d: in_a=%b in_v=%b", cycle, in_a, in_v);
            end
            acc       = in_v & in_a;
            popped    = out_v && out_a;
            hold_prev = out_v && !out_a;
            held      = out_d;
            if (popped) begin
                tag = out_d[N +: IdxW];
                checks++;
                if (exp_q[tag].size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected_word cycle %0d: out_d=%h with no pending word", cycle, out_d);
                end else begin
                    front = exp_q[tag].pop_front();
                    if (out_d[N-1:0] !== front) begin
                        errors++;
                        $display("FAIL rnd_order cycle %0d: src %0d data %h expected %h",
                                 cycle, tag, out_d[N-1:0], front);
                    end
                end
                received++;
            end
            for (int i = 0; i < NumIn; i++) begin
                if (acc[i]) exp_q[i].push_back(in_d[i*N +: N]);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rnd_timeout: traffic did not drain within 2000 cycles");
        end
        checks++;
        if (received != NumIn * Limit) begin
            errors++;
            $display("FAIL rnd_total: received %0d words expected %0d", received, NumIn * Limit);
        end
        in_v  = '0;
        out_a = 1'b0;
    endtask

`ifdef CHANNEL_MERGE_COUNT_EN
    task automatic test_count();
        do_reset();
        set_d(0, 8'h3C);
        in_v  = 4'b0001;
        out_a = 1'b1;
        repeat (70000) @(negedge clk);
        in_v = '0;
        @(negedge clk);
        checks++;
        if (xfer_count[15:0] !== 16'd4464 || xfer_count[NumIn*16-1:16] !== '0) begin
            errors++;
            $display("FAIL count_wrap: xfer_count=%h expected counter0=1170 others 0", xfer_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_all_rr();
        test_backpressure();
        test_alternate();
        test_reset_full();
        test_random();
`ifdef CHANNEL_MERGE_COUNT_EN
        test_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
